// File: rtl/decode_issue_pkg.sv
// Shared CPU definitions: instruction field layout, datapath width and the
// per-opcode register-write table used by decode/issue and execute.
package decode_issue_pkg;

    localparam int unsigned DataW   = 16;
    localparam int unsigned RegW    = 4;
    localparam int unsigned NumRegs = 16;

    localparam int unsigned OpMsb  = 15;
    localparam int unsigned OpLsb  = 12;
    localparam int unsigned RdMsb  = 11;
    localparam int unsigned RdLsb  = 8;
    localparam int unsigned Rs1Msb = 7;
    localparam int unsigned Rs1Lsb = 4;
    localparam int unsigned Rs2Msb = 3;
    localparam int unsigned Rs2Lsb = 0;

    // Bit n set means opcode n writes rd: 0x0-0xB write, 0xC-0xF do not.
    localparam logic [15:0] WeTable = 16'h0FFF;

    typedef struct packed {
        logic [RegW-1:0] op;
        logic [RegW-1:0] rd;
        logic [RegW-1:0] rs1;
        logic [RegW-1:0] rs2;
    } instr_t;

    function automatic logic op_writes(input logic [RegW-1:0] op);
        return WeTable[op];
    endfunction

endpackage

// File: rtl/decode_issue_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at
// write-back; a same-cycle set and clear of one bit leaves it set.
module issue_scoreboard
    import decode_issue_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            set_i,
    input  logic [RegW-1:0] set_idx_i,
    input  logic            clr_i,
    input  logic [RegW-1:0] clr_idx_i,
    input  logic [RegW-1:0] q1_idx_i,
    input  logic [RegW-1:0] q2_idx_i,
    output logic            q1_pend_o,
    output logic            q2_pend_o
);

    logic [NumRegs-1:0] pend_q, pend_d;
    logic [NumRegs-1:0] set_mask, clr_mask, pend_eff;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_i) set_mask[set_idx_i] = 1'b1;
        if (clr_i) clr_mask[clr_idx_i] = 1'b1;
        // A register being written back this cycle is covered by the bypass.
        pend_eff  = pend_q & ~clr_mask;
        pend_d    = pend_eff | set_mask;
        q1_pend_o = pend_eff[q1_idx_i];
        q2_pend_o = pend_eff[q2_idx_i];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) pend_q <= '0;
        else         pend_q <= pend_d;
    end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: valid/ready handshake, RAW interlock via the scoreboard
// and write-back bypass onto the registered register-file read data.
module decode_issue
    import decode_issue_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [DataW-1:0] IN_INSTR,
    output logic [RegW-1:0]  R1A,
    output logic [RegW-1:0]  R2A,
    input  logic [DataW-1:0] R1D,
    input  logic [DataW-1:0] R2D,
    input  logic             WB_RW,
    input  logic [RegW-1:0]  WB_WA,
    input  logic [DataW-1:0] WB_RWD,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [RegW-1:0]  OUT_OP,
    output logic [RegW-1:0]  OUT_RD,
    output logic             OUT_WE,
    output logic [DataW-1:0] OUT_IMM,
    output logic [DataW-1:0] OUT_A,
    output logic [DataW-1:0] OUT_B
);

    instr_t           in_f;
    instr_t           held_q, held_d;
    logic             valid_q, valid_d;
    logic             we_q, we_d;
    logic [DataW-1:0] imm_q, imm_d;
    logic             byp1_q, byp1_d, byp2_q, byp2_d;
    logic [DataW-1:0] wbd_q, wbd_d;
    logic             hold, hazard, accept;
    logic             rs1_pend, rs2_pend;

    assign in_f = instr_t'(IN_INSTR);

    issue_scoreboard u_sb (
        .clk_i     (CLK),
        .reset_i   (RESET),
        .set_i     (accept && op_writes(in_f.op)),
        .set_idx_i (in_f.rd),
        .clr_i     (WB_RW),
        .clr_idx_i (WB_WA),
        .q1_idx_i  (in_f.rs1),
        .q2_idx_i  (in_f.rs2),
        .q1_pend_o (rs1_pend),
        .q2_pend_o (rs2_pend)
    );

    always_comb begin
        hold     = valid_q && !OUT_READY;
        // While held, keep re-reading the held sources so OUT_A/B stay current.
        R1A      = hold ? held_q.rs1 : in_f.rs1;
        R2A      = hold ? held_q.rs2 : in_f.rs2;
        hazard   = IN_VALID && (rs1_pend || rs2_pend);
        IN_READY = !RESET && (!valid_q || OUT_READY) && !hazard;
        accept   = IN_VALID && IN_READY;
    end

    always_comb begin
        valid_d = valid_q;
        held_d  = held_q;
        we_d    = we_q;
        imm_d   = imm_q;
        if (accept) begin
            valid_d = 1'b1;
            held_d  = in_f;
            we_d    = op_writes(in_f.op);
            imm_d   = {{(DataW - RegW){in_f.rs2[RegW-1]}}, in_f.rs2};
        end else if (valid_q && OUT_READY) begin
            valid_d = 1'b0;
        end
        // The register file returns the old value on a same-edge write, so
        // remember the write-back data for the address being read.
        byp1_d = WB_RW && (WB_WA == R1A);
        byp2_d = WB_RW && (WB_WA == R2A);
        wbd_d  = WB_RWD;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= 1'b0;
            held_q  <= '0;
            we_q    <= 1'b0;
            imm_q   <= '0;
            byp1_q  <= 1'b0;
            byp2_q  <= 1'b0;
            wbd_q   <= '0;
        end else begin
            valid_q <= valid_d;
            held_q  <= held_d;
            we_q    <= we_d;
            imm_q   <= imm_d;
            byp1_q  <= byp1_d;
            byp2_q  <= byp2_d;
            wbd_q   <= wbd_d;
        end
    end

    always_comb begin
        OUT_VALID = valid_q;
        OUT_OP    = held_q.op;
        OUT_RD    = held_q.rd;
        OUT_WE    = we_q;
        OUT_IMM   = imm_q;
        OUT_A     = byp1_q ? wbd_q : R1D;
        OUT_B     = byp2_q ? wbd_q : R2D;
    end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue with a registered-read register file model.
module tb_decode_issue;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] IN_INSTR;
    logic [3:0]  R1A, R2A;
    logic [15:0] R1D, R2D;
    logic        WB_RW;
    logic [3:0]  WB_WA;
    logic [15:0] WB_RWD;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [3:0]  OUT_OP, OUT_RD;
    logic        OUT_WE;
    logic [15:0] OUT_IMM, OUT_A, OUT_B;

    logic [15:0] regs [16];

    int    checks   = 0;
    int    failures = 0;
    string ctx      = "";

    decode_issue dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_INSTR  (IN_INSTR),
        .R1A       (R1A),
        .R2A       (R2A),
        .R1D       (R1D),
        .R2D       (R2D),
        .WB_RW     (WB_RW),
        .WB_WA     (WB_WA),
        .WB_RWD    (WB_RWD),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_OP    (OUT_OP),
        .OUT_RD    (OUT_RD),
        .OUT_WE    (OUT_WE),
        .OUT_IMM   (OUT_IMM),
        .OUT_A     (OUT_A),
        .OUT_B     (OUT_B)
    );

    always #5 CLK = ~CLK;

    // Register file: r[k] = 0x1111*k except r3 = 0x1234; read data is
    // registered and a same-edge write returns the old value.
    always @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < 16; k++) regs[k] <= 16'(16'h1111 * k);
            regs[3] <= 16'h1234;
        end else if (WB_RW) begin
            regs[WB_WA] <= WB_RWD;
        end
        R1D <= regs[R1A];
        R2D <= regs[R2A];
    end

    typedef struct {
        logic        iv;
        logic [15:0] instr;
        logic        ordy;
        logic        wrw;
        logic [3:0]  wwa;
        logic [15:0] wwd;
        logic        rdy;
        logic        ov;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic        we;
        logic [15:0] imm;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] pend;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic iv, input logic [15:0] instr, input logic ordy,
                                input logic wrw, input logic [3:0] wwa, input logic [15:0] wwd,
                                input logic rdy, input logic ov, input logic [3:0] op,
                                input logic [3:0] rd, input logic we, input logic [15:0] imm,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] pend);
        vec_t v;
        v.iv = iv; v.instr = instr; v.ordy = ordy; v.wrw = wrw; v.wwa = wwa; v.wwd = wwd;
        v.rdy = rdy; v.ov = ov; v.op = op; v.rd = rd; v.we = we; v.imm = imm;
        v.a = a; v.b = b; v.pend = pend;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s: got %h expected %h", ctx, nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [15:0] instr, input logic ordy,
                         input logic wrw, input logic [3:0] wwa, input logic [15:0] wwd);
        IN_VALID  = iv;
        IN_INSTR  = instr;
        OUT_READY = ordy;
        WB_RW     = wrw;
        WB_WA     = wwa;
        WB_RWD    = wwd;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1;
        drive(1'b1, 16'h1530, 1'b1, 1'b0, 4'h0, 16'h0000);

        // Columns: iv instr ordy wrw wwa wwd | rdy ov op rd we imm a b pend
        // Basic accept, RAW stall then bypassed release.
        vq.push_back(mk(1, 16'h1530, 1, 0, 4'h0, 16'h0000, 1, 1, 4'h1, 4'h5, 1, 16'h0000, 16'h1234, 16'h0000, 16'h0020));
        vq.push_back(mk(1, 16'h2650, 1, 0, 4'h0, 16'h0000, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0020));
        vq.push_back(mk(1, 16'h2650, 1, 0, 4'h0, 16'h0000, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0020));
        vq.push_back(mk(1, 16'h2650, 1, 1, 4'h5, 16'hBEEF, 1, 1, 4'h2, 4'h6, 1, 16'h0000, 16'hBEEF, 16'h0000, 16'h0040));
        // Three-cycle hold with a write-back to the held rs1 mid-hold.
        vq.push_back(mk(1, 16'h1120, 0, 0, 4'h0, 16'h0000, 0, 1, 4'h2, 4'h6, 1, 16'h0000, 16'hBEEF, 16'h0000, 16'h0040));
        vq.push_back(mk(1, 16'h1120, 0, 1, 4'h5, 16'hCAFE, 0, 1, 4'h2, 4'h6, 1, 16'h0000, 16'hCAFE, 16'h0000, 16'h0040));
        vq.push_back(mk(1, 16'h1120, 0, 0, 4'h0, 16'h0000, 0, 1, 4'h2, 4'h6, 1, 16'h0000, 16'hCAFE, 16'h0000, 16'h0040));
        // Back-to-back independent ops, r6 retired on the first one.
        vq.push_back(mk(1, 16'h1120, 1, 1, 4'h6, 16'h0606, 1, 1, 4'h1, 4'h1, 1, 16'h0000, 16'h2222, 16'h0000, 16'h0002));
        vq.push_back(mk(1, 16'h1343, 1, 0, 4'h0, 16'h0000, 1, 1, 4'h1, 4'h3, 1, 16'h0003, 16'h4444, 16'h1234, 16'h000A));
        vq.push_back(mk(1, 16'h1560, 1, 0, 4'h0, 16'h0000, 1, 1, 4'h1, 4'h5, 1, 16'h0000, 16'h0606, 16'h0000, 16'h002A));
        vq.push_back(mk(0, 16'h0000, 1, 0, 4'h0, 16'h0000, 1, 0, 4'h0, 4'h0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h002A));
        // Non-writing opcode with negative immediate.
        vq.push_back(mk(1, 16'hC07F, 1, 0, 4'h0, 16'h0000, 1, 1, 4'hC, 4'h0, 0, 16'hFFFF, 16'h7777, 16'hFFFF, 16'h002A));
        vq.push_back(mk(0, 16'h0000, 1, 0, 4'h0, 16'h0000, 1, 0, 4'h0, 4'h0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h002A));
        // Hazard through rs2 alone.
        vq.push_back(mk(1, 16'h2043, 1, 0, 4'h0, 16'h0000, 0, 0, 4'h0, 4'h0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h002A));

        // Reset state.
        ctx = "reset";
        tick();
        tick();
        chk("in_ready", 16'(IN_READY), 16'h0);
        chk("out_valid", 16'(OUT_VALID), 16'h0);
        chk("out_we", 16'(OUT_WE), 16'h0);
        chk("pend", dut.u_sb.pend_q, 16'h0000);
        RESET = 1'b0;
        #1;
        chk("r1a", 16'(R1A), 16'h3);

        foreach (vq[i]) begin
            ctx = $sformatf("vec%0d", i);
            drive(vq[i].iv, vq[i].instr, vq[i].ordy, vq[i].wrw, vq[i].wwa, vq[i].wwd);
            #1;
            chk("in_ready", 16'(IN_READY), 16'(vq[i].rdy));
            tick();
            chk("out_valid", 16'(OUT_VALID), 16'(vq[i].ov));
            if (vq[i].ov) begin
                chk("out_op", 16'(OUT_OP), 16'(vq[i].op));
                chk("out_rd", 16'(OUT_RD), 16'(vq[i].rd));
                chk("out_we", 16'(OUT_WE), 16'(vq[i].we));
                chk("out_imm", OUT_IMM, vq[i].imm);
                chk("out_a", OUT_A, vq[i].a);
                chk("out_b", OUT_B, vq[i].b);
            end
            chk("pend", dut.u_sb.pend_q, vq[i].pend);
        end

        // Set wins over a same-edge write-back clear of r7.
        ctx = "setwins";
        drive(1'b1, 16'h1700, 1'b1, 1'b0, 4'h0, 16'h0000);
        tick();
        chk("pend_set7", dut.u_sb.pend_q, 16'h00AA);
        drive(1'b1, 16'h1780, 1'b1, 1'b1, 4'h7, 16'h7070);
        #1;
        chk("in_ready", 16'(IN_READY), 16'h1);
        tick();
        chk("out_rd", 16'(OUT_RD), 16'h7);
        chk("pend_collide", dut.u_sb.pend_q, 16'h00AA);
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 4'h7, 16'h7070);
        tick();
        chk("pend_clr7", dut.u_sb.pend_q, 16'h002A);

        // Reset while an instruction is held with r2 and r9 pending.
        ctx = "rsthold";
        RESET = 1'b1;
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 4'h0, 16'h0000);
        tick();
        RESET = 1'b0;
        drive(1'b1, 16'h1200, 1'b1, 1'b0, 4'h0, 16'h0000);
        tick();
        drive(1'b1, 16'h1900, 1'b1, 1'b0, 4'h0, 16'h0000);
        tick();
        drive(1'b1, 16'h3020, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1;
        chk("in_ready_hold", 16'(IN_READY), 16'h0);
        tick();
        chk("out_valid_hold", 16'(OUT_VALID), 16'h1);
        chk("out_rd_hold", 16'(OUT_RD), 16'h9);
        chk("pend_hold", dut.u_sb.pend_q, 16'h0204);
        RESET = 1'b1;
        #1;
        chk("in_ready_rst", 16'(IN_READY), 16'h0);
        tick();
        chk("out_valid_rst", 16'(OUT_VALID), 16'h0);
        chk("out_we_rst", 16'(OUT_WE), 16'h0);
        chk("pend_rst", dut.u_sb.pend_q, 16'h0000);
        RESET = 1'b0;
        #1;
        chk("r1a_post", 16'(R1A), 16'h2);
        chk("in_ready_post", 16'(IN_READY), 16'h1);
        tick();
        chk("out_valid_post", 16'(OUT_VALID), 16'h1);
        chk("out_op_post", 16'(OUT_OP), 16'h3);
        chk("out_a_post", OUT_A, 16'h2222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have port CLK, in, 1, rising-edge clock.
REQ-002 SHALL have port RESET, in, 1, synchronous, active-high reset.
REQ-003 SHALL have ports IN_VALID in 1, IN_READY out 1, IN_INSTR in 16; instruction fields are opcode [15:12], rd [11:8], rs1 [7:4], rs2/imm [3:0].
REQ-004 SHALL have ports R1A out 4 and R2A out 4, which drive the register-file read addresses.
REQ-005 SHALL have ports R1D in 16 and R2D in 16; this is register-file read data, registered, available one cycle after the address.
REQ-006 SHALL have ports WB_RW in 1, WB_WA in 4, WB_RWD in 16; this is the write-back port, identical to the register-file write inputs.
REQ-007 SHALL have ports OUT_VALID out 1, OUT_READY in 1, OUT_OP out 4, OUT_RD out 4, OUT_WE out 1, OUT_IMM out 16, OUT_A out 16, OUT_B out 16.

Function
REQ-008 SHALL accept an instruction on the rising edge where IN_VALID && IN_READY.
REQ-009 SHALL compute IN_READY = (!OUT_VALID || OUT_READY) && !hazard; IN_READY is combinational from IN_INSTR by design.
REQ-010 SHALL drive R1A/R2A as follows: when OUT_VALID && !OUT_READY, the held rs1/rs2; otherwise IN_INSTR[7:4]/[3:0].
REQ-011 SHALL, on accept, register the op, rd and rs fields, set OUT_VALID=1 the next cycle, and give an accept-to-OUT_VALID latency of 1 cycle.
REQ-012 SHALL compute OUT_WE = 1 for opcodes 0x0-0xB and 0 for 0xC-0xF.
REQ-013 SHALL compute OUT_IMM = IN_INSTR[3:0] sign-extended to 16 bits, registered at accept.
REQ-014 SHALL clear OUT_VALID on an edge with OUT_VALID && OUT_READY and no new accept.
REQ-015 SHALL hold all OUT_* fields stable while OUT_VALID && !OUT_READY.
REQ-016 SHALL keep OUT_A/OUT_B current during a hold, because R1A/R2A re-read the held address every cycle.
REQ-017 SHALL implement write-back bypass: at every edge, capture byp1 = WB_RW && (WB_WA == R1A) and byp2 likewise for R2A, along with WB_RWD.
REQ-018 SHALL select OUT_A = byp1 ? captured WB_RWD : R1D, and likewise OUT_B; this covers the register file returning the old value on a same-edge read/write.
REQ-019 SHALL maintain a 16-bit pending scoreboard: set bit rd at accept when OUT_WE of the accepted op is 1; clear bit WB_WA on WB_RW.
REQ-020 SHALL resolve a simultaneous set and clear of the same bit with set winning.
REQ-021 SHALL compute hazard = IN_VALID && (pend_eff[rs1] || pend_eff[rs2]), where pend_eff = pending with the bit for the current cycle's WB clear masked off (bypass covers it).
REQ-022 SHALL check both rs fields for every opcode, including immediate forms (deliberately conservative).
REQ-023 SHALL leave scoreboard bits of writes that never reach WB set; flushing is out of scope.

Reset
REQ-024 SHALL, on RESET, clear OUT_VALID, OUT_WE, the scoreboard, byp1/byp2 and all held fields to 0; OUT_A/OUT_B are don't-care while OUT_VALID=0.
REQ-025 SHALL hold IN_READY at 0 during a RESET cycle, with no accept.
REQ-026 SHALL discard an in-flight or held instruction when RESET is asserted mid-operation.
REQ-027 SHALL make R1A/R2A follow IN_INSTR after reset.

Structure
REQ-028 SHALL place opcode field positions, the OUT_WE opcode table and the 16-bit data width in a shared CPU package, reused by the execute stage.
REQ-029 SHALL implement the scoreboard (set/clear/query, set-wins rule) as sub-module issue_scoreboard.
REQ-030 SHALL keep the bypass and handshake logic in decode_issue.

Verification
REQ-031 SHALL cover basic accept: reg 3 = 0x1234, instruction 0x1530 accepted with OUT_READY=1 -> next cycle OUT_VALID=1, OUT_OP=1, OUT_RD=5, OUT_A=0x1234, OUT_WE=1, pending[5]=1.
REQ-032 SHALL cover RAW stall: after accepting 0x1530, present 0x2650 -> IN_READY=0 until WB_RW=1 with WB_WA=5 and WB_RWD=0xBEEF; the accept happens in that same cycle and next cycle OUT_A=0xBEEF via bypass.
REQ-033 SHALL cover backpressure: OUT_READY=0 for 3 cycles with OUT_VALID=1 -> OUT_* stable and IN_READY=0; a write-back to the held rs1 during the hold shows the new value on OUT_A within 1 cycle.
REQ-034 SHALL cover back-to-back independent ops: 0x1120, 0x1340, 0x1560 with OUT_READY=1 -> one accept per cycle, OUT_VALID continuously 1, pending={1,3,5}.
REQ-035 SHALL cover set-wins collision: a WB clear of reg 7 on the same edge as accepting an instruction with rd=7 -> pending[7]=1 afterwards.
REQ-036 SHALL cover reset mid-hold: RESET during OUT_VALID=1 with pending={2,9} -> next cycle OUT_VALID=0, pending=0, first post-reset instruction reading r2 accepted with no stall.
